// File: rtl/sub_sched.sv
// sub_sched: shares four S-boxes between SubBytes (128b) and SubWord (32b).
// Define SUB_SCHED_KS_PRIO_EN for key priority with mid-state insertion.
module sub_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         ks_req,
  input  logic [31:0]  ks_in,
  output logic         ks_done,
  output logic [31:0]  ks_out,
  output logic         busy
);

  // byte x lives at SBOX[2047-8x -: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3,
`ifdef SUB_SCHED_KS_PRIO_EN
    KS,
    KS_INS
`else
    KS
`endif
  } state_t;

  state_t state, nxt;

  logic [127:0] st_buf;
  logic [31:0]  ks_buf;
  logic [31:0]  mux;
  logic [31:0]  sub;
  logic         last_st;
  logic         lg_nxt;
  logic         ld_st, ld_ks;
  logic         wr_ks;
  logic [3:0]   wr_col;
  logic         st_fin, ks_fin;
  logic         st_q, ks_q;
  logic         ks_wins;

`ifdef SUB_SCHED_KS_PRIO_EN
  state_t resume, resume_nxt;
`endif

  assign st_q = st_req & ~st_done;
  assign ks_q = ks_req & ~ks_done;
  assign busy = (state != IDLE);

`ifdef SUB_SCHED_KS_PRIO_EN
  assign ks_wins = 1'b1;
`else
  assign ks_wins = last_st;
`endif

  always_comb begin
    mux = ks_buf;
    unique case (state)
      ST_W0:   mux = st_buf[127:96];
      ST_W1:   mux = st_buf[95:64];
      ST_W2:   mux = st_buf[63:32];
      ST_W3:   mux = st_buf[31:0];
      default: mux = ks_buf;
    endcase
  end

  assign sub = {sbox(mux[31:24]), sbox(mux[23:16]),
                sbox(mux[15:8]),  sbox(mux[7:0])};

  always_comb begin
    nxt    = state;
    lg_nxt = last_st;
    ld_st  = 1'b0;
    ld_ks  = 1'b0;
    wr_ks  = 1'b0;
    wr_col = 4'b0000;
    st_fin = 1'b0;
    ks_fin = 1'b0;
`ifdef SUB_SCHED_KS_PRIO_EN
    resume_nxt = resume;
`endif
    unique case (state)
      IDLE: begin
        if (ks_q && (!st_q || ks_wins)) begin
          nxt    = KS;
          ld_ks  = 1'b1;
          lg_nxt = 1'b0;
        end else if (st_q) begin
          nxt    = ST_W0;
          ld_st  = 1'b1;
          lg_nxt = 1'b1;
        end
      end
      ST_W0: begin
        wr_col[0] = 1'b1;
        nxt       = ST_W1;
      end
      ST_W1: begin
        wr_col[1] = 1'b1;
        nxt       = ST_W2;
      end
      ST_W2: begin
        wr_col[2] = 1'b1;
        nxt       = ST_W3;
      end
      ST_W3: begin
        wr_col[3] = 1'b1;
        st_fin    = 1'b1;
        nxt       = IDLE;
      end
      KS: begin
        wr_ks  = 1'b1;
        ks_fin = 1'b1;
        nxt    = IDLE;
      end
`ifdef SUB_SCHED_KS_PRIO_EN
      KS_INS: begin
        wr_ks  = 1'b1;
        ks_fin = 1'b1;
        nxt    = resume;
      end
`endif
      default: nxt = IDLE;
    endcase
`ifdef SUB_SCHED_KS_PRIO_EN
    // divert after the current column; resume at the following one
    if (ks_q && (state == ST_W0 || state == ST_W1 ||
                 state == ST_W2)) begin
      resume_nxt = nxt;
      nxt        = KS_INS;
      ld_ks      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef SUB_SCHED_KS_PRIO_EN
      resume <= IDLE;
`endif
    end else begin
      state <= nxt;
`ifdef SUB_SCHED_KS_PRIO_EN
      resume <= resume_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_buf  <= '0;
      ks_buf  <= '0;
      st_out  <= '0;
      ks_out  <= '0;
      st_done <= 1'b0;
      ks_done <= 1'b0;
      last_st <= 1'b1;
    end else begin
      st_done <= st_fin;
      ks_done <= ks_fin;
      last_st <= lg_nxt;
      if (ld_st) st_buf <= st_in;
      if (ld_ks) ks_buf <= ks_in;
      if (wr_ks) ks_out <= sub;
      if (wr_col[0]) st_out[127:96] <= sub;
      if (wr_col[1]) st_out[95:64]  <= sub;
      if (wr_col[2]) st_out[63:32]  <= sub;
      if (wr_col[3]) st_out[31:0]   <= sub;
    end
  end

endmodule
